// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_rx_pkg
// Brief    : Shared types and constants for the UART receive drain path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Width of one received character.
  localparam int BYTE_W = 8;

  // Default FIFO depth (power of two, at least 2).
  localparam int DEFAULT_DEPTH = 8;

  // Default width of the saturating dropped-byte counter.
  localparam int DEFAULT_DROP_W = 8;

  // Handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK      = 2'd2,
    WAIT_CLR = 2'd3
  } drain_state_t;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo
// Brief    : First-word fall-through byte FIFO. The head entry is always
//            visible on rd_data; a pop on an empty FIFO is ignored and a push
//            into a full FIFO is only taken when a pop frees a slot in the
//            same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

  // A pop is only meaningful when something is stored; a push into a full
  // FIFO is only safe when that same-cycle pop releases the head slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Fall-through read: head byte is presented without a pop request.
  assign rd_data = mem[rd_ptr];

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : rx_fifo
`default_nettype wire

// File: rtl/rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_drain_ctrl
// Brief    : Drains the UART receiver's single-byte buffer into a local FIFO.
//            Each data_ready is captured exactly once, acknowledged with a
//            one-cycle data_read pulse, and the sequencer then waits for the
//            receiver to drop data_ready before arming again. Bytes arriving
//            while the FIFO is full are discarded but still acknowledged, and
//            the loss is recorded in sticky status plus a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module rx_drain_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DROP_W = DEFAULT_DROP_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              data_ready,
  input  logic              overrun_error,
  input  logic              framing_error,
  output logic              data_read,
  input  logic              fifo_rd,
  output logic [BYTE_W-1:0] fifo_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  fifo_count,
  input  logic              clear_err,
  output logic              err_framing,
  output logic              err_overrun,
  output logic              err_drop,
  output logic [DROP_W-1:0] drop_count
);

  drain_state_t      state;
  drain_state_t      state_nxt;
  logic              capture;
  logic              accept;
  logic              drop;
  logic [DROP_W-1:0] drop_base;
  logic [DROP_W-1:0] drop_count_nxt;

  // The byte is sampled in the CAPTURE cycle. A host pop in that same cycle
  // frees the head slot, so a full FIFO can still take the byte.
  assign capture = (state == CAPTURE);
  assign accept  = capture && (!fifo_full || fifo_rd);
  assign drop    = capture && !accept;

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (accept),
    .wr_data (rx_data),
    .pop     (fifo_rd),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Sequencer state register; async reset also kills data_read at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore acknowledge. WAIT_CLR blocks re-capture of a
  // data_ready level the receiver has not yet withdrawn.
  always_comb begin
    state_nxt = state;
    data_read = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_ready) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = ACK;
      end
      ACK: begin
        data_read = 1'b1;
        state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!data_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Drop counter update: a clear empties it first, then a coincident drop
  // still counts, so a drop in the clearing cycle leaves the counter at one.
  always_comb begin
    drop_base      = clear_err ? '0 : drop_count;
    drop_count_nxt = drop_base;
    if (drop && (drop_base != {DROP_W{1'b1}})) begin
      drop_count_nxt = drop_base + DROP_W'(1);
    end
  end

  // Sticky status: a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_framing <= 1'b0;
      err_overrun <= 1'b0;
      err_drop    <= 1'b0;
      drop_count  <= '0;
    end else begin
      err_framing <= framing_error | (err_framing & ~clear_err);
      err_overrun <= overrun_error | (err_overrun & ~clear_err);
      err_drop    <= drop | (err_drop & ~clear_err);
      drop_count  <= drop_count_nxt;
    end
  end

endmodule : rx_drain_ctrl
`default_nettype wire

// File: tb/tb_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_drain_ctrl
// Brief    : Directed and randomized bench for rx_drain_ctrl, checked against
//            a queue-based model of the FIFO and error bookkeeping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_drain_ctrl;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic              clk;
  logic              n_rst;
  logic [7:0]        rx_data;
  logic              data_ready;
  logic              overrun_error;
  logic              framing_error;
  logic              data_read;
  logic              fifo_rd;
  logic [7:0]        fifo_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              clear_err;
  logic              err_framing;
  logic              err_overrun;
  logic              err_drop;
  logic [DROP_W-1:0] drop_count;

  rx_drain_ctrl #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .data_read     (data_read),
    .fifo_rd       (fifo_rd),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .clear_err     (clear_err),
    .err_framing   (err_framing),
    .err_overrun   (err_overrun),
    .err_drop      (err_drop),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored bytes in arrival order plus error bookkeeping.
  logic [7:0] q[$];
  int         m_drops;
  bit         m_ef;
  bit         m_eo;
  bit         m_ed;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drops = 0;
    m_ef    = 1'b0;
    m_eo    = 1'b0;
    m_ed    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":count"},   32'(fifo_count), 32'(q.size()));
    chk({tag, ":empty"},   32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, ":full"},    32'(fifo_full),  32'(q.size() == DEPTH));
    chk({tag, ":err_fr"},  32'(err_framing), 32'(m_ef));
    chk({tag, ":err_ov"},  32'(err_overrun), 32'(m_eo));
    chk({tag, ":err_dr"},  32'(err_drop),    32'(m_ed));
    chk({tag, ":dropcnt"}, 32'(drop_count),  32'(m_drops));
    if (q.size() > 0) chk({tag, ":head"}, 32'(fifo_data), 32'(q[0]));
  endtask

  // One full receiver handshake starting from IDLE. Optional host pop and
  // error clear land in the CAPTURE cycle; data_ready is held 'hold' extra
  // cycles in WAIT_CLR to show a held level is not captured twice.
  task automatic send(input logic [7:0] b, input bit pop_cap, input bit clr_cap, input int hold);
    rx_data    = b;
    data_ready = 1'b1;
    tick();                                   // CAPTURE
    chk("cap:data_read", 32'(data_read), 32'd0);
    if (clr_cap) begin
      clear_err = 1'b1;
      m_ef = 1'b0; m_eo = 1'b0; m_ed = 1'b0; m_drops = 0;
    end
    if (pop_cap) begin
      if (q.size() > 0) chk("cap:pop_head", 32'(fifo_data), 32'(q[0]));
      fifo_rd = 1'b1;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (q.size() < DEPTH) begin
      q.push_back(b);
    end else begin
      m_ed = 1'b1;
      if (m_drops < DMAX) m_drops++;
    end
    tick();                                   // ACK
    fifo_rd   = 1'b0;
    clear_err = 1'b0;
    chk("ack:data_read", 32'(data_read), 32'd1);
    check_state("ack");
    tick();                                   // WAIT_CLR, data_ready still high
    chk("wclr:data_read", 32'(data_read), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold:data_read", 32'(data_read), 32'd0);
      chk("hold:count", 32'(fifo_count), 32'(q.size()));
    end
    data_ready = 1'b0;
    tick();                                   // back to IDLE
    chk("idle:data_read", 32'(data_read), 32'd0);
  endtask

  task automatic pop_one();
    if (q.size() > 0) chk("pop:head", 32'(fifo_data), 32'(q[0]));
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_state("pop");
  endtask

  task automatic err_cycle(input bit fr, input bit ov, input bit clr);
    framing_error = fr;
    overrun_error = ov;
    clear_err     = clr;
    tick();
    framing_error = 1'b0;
    overrun_error = 1'b0;
    clear_err     = 1'b0;
    m_ef = fr | (m_ef & !clr);
    m_eo = ov | (m_eo & !clr);
    if (clr) begin
      m_ed    = 1'b0;
      m_drops = 0;
    end
    check_state("err");
  endtask

  initial begin
    n_rst = 1'b0; rx_data = '0; data_ready = 1'b0; overrun_error = 1'b0;
    framing_error = 1'b0; fifo_rd = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (3) tick();

    // Reset values.
    chk("rst:data_read", 32'(data_read), 32'd0);
    chk("rst:fifo_data", 32'(fifo_data), 32'd0);
    check_state("rst");
    n_rst = 1'b1;
    tick();

    // Single byte with latency checks.
    send(8'hA5, 1'b0, 1'b0, 0);
    chk("single:head", 32'(fifo_data), 32'h00A5);
    pop_one();

    // Fill and overflow: ninth byte dropped but still acknowledged.
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0, 0);
    chk("fill:full", 32'(fifo_full), 32'd1);
    chk("fill:err_drop", 32'(err_drop), 32'd1);
    chk("fill:drop_count", 32'(drop_count), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("fill:order", 32'(fifo_data), 32'(i));
      pop_one();
    end

    // Full FIFO with host pop in the CAPTURE cycle.
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 1'b0, 1'b0, 0);
    send(8'h3C, 1'b1, 1'b0, 0);
    chk("fullpop:count", 32'(fifo_count), 32'd8);
    chk("fullpop:drop_count", 32'(drop_count), 32'd1);
    // Second drop, then a drop coinciding with clear: counter reloads to one.
    send(8'hEE, 1'b0, 1'b0, 0);
    chk("drop2:drop_count", 32'(drop_count), 32'd2);
    send(8'hEF, 1'b0, 1'b1, 0);
    chk("clrdrop:drop_count", 32'(drop_count), 32'd1);
    for (int i = 0; i < 8; i++) pop_one();
    chk("fullpop:empty", 32'(fifo_empty), 32'd1);

    // Wrap-around with interleaved push/pop.
    send(8'h10, 1'b0, 1'b0, 0);
    for (int i = 1; i < 20; i++) begin
      send(8'h10 + 8'(i), 1'b0, 1'b0, 0);
      chk("wrap:count_le2", 32'(fifo_count <= 2), 32'd1);
      chk("wrap:order", 32'(fifo_data), 32'h10 + 32'(i - 1));
      pop_one();
    end
    pop_one();
    pop_one();                                // pop on empty is ignored

    // Sticky error flags.
    err_cycle(1'b1, 1'b0, 1'b0);
    err_cycle(1'b0, 1'b0, 1'b0);
    chk("err:framing_held", 32'(err_framing), 32'd1);
    err_cycle(1'b0, 1'b1, 1'b1);
    chk("err:overrun_wins", 32'(err_overrun), 32'd1);
    err_cycle(1'b0, 1'b0, 1'b1);
    chk("err:cleared", 32'({err_framing, err_overrun, err_drop}), 32'd0);

    // Drop counter saturation.
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 0);
    for (int i = 0; i < DMAX + 5; i++) send(8'hD0, 1'b0, 1'b0, 0);
    chk("sat:drop_count", 32'(drop_count), 32'(DMAX));
    err_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_one();

    // Randomized traffic against the model.
    for (int it = 0; it < 200; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        send(8'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 2)));
      end else if (op <= 7) begin
        pop_one();
      end else begin
        err_cycle(1'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    // Reset in ACK with three bytes queued.
    while (q.size() > 0) pop_one();
    send(8'h01, 1'b0, 1'b0, 0);
    send(8'h02, 1'b0, 1'b0, 0);
    send(8'h03, 1'b0, 1'b0, 0);
    rx_data    = 8'h04;
    data_ready = 1'b1;
    tick();                                   // CAPTURE
    tick();                                   // ACK
    chk("midrst:ack", 32'(data_read), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("midrst:data_read", 32'(data_read), 32'd0);
    chk("midrst:empty", 32'(fifo_empty), 32'd1);
    data_ready = 1'b0;
    model_reset();
    tick();
    check_state("midrst");
    n_rst = 1'b1;
    tick();
    send(8'h77, 1'b0, 1'b0, 0);
    chk("post:head", 32'(fifo_data), 32'h0077);
    chk("post:count", 32'(fifo_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rx_drain_ctrl
`default_nettype wire
